uart_rx_buf_ctrl: RTL and testbench
===================================

UART_RX_BUF_CTRL -- requirements
Module: uart_rx_buf_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of 2, 2..64); AW = log2(DEPTH).
REQ-002 SHALL have parameter TO_TICKS, default 32, receive-tick count for the character timeout (1..255).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port iCLK  input  1  the single clock, rising edge.
REQ-005 SHALL have port iRESET  input  1  synchronous active-high reset.
REQ-006 SHALL have port iRX_DATA  input  8  received byte from the UART receive controller.
REQ-007 SHALL have port iRX_DATA_EN  input  1  one-cycle pulse marking iRX_DATA valid.
REQ-008 SHALL have port iRX_TICK  input  1  receive sampling tick, one cycle wide.
REQ-009 SHALL have port iRD_REQ  input  1  pop request from the bus side.
REQ-010 SHALL have port iTHRESH  input  AW+1  IRQ fill level; 0 disables the IRQ.
REQ-011 SHALL have port iCLR_OVR  input  1  clears the overrun flag.
REQ-012 SHALL have port oRD_DATA  output  8  popped byte.
REQ-013 SHALL have port oRD_VALID  output  1  one-cycle pulse marking oRD_DATA valid.
REQ-014 SHALL have port oCOUNT  output  AW+1  current fill level, 0..DEPTH.
REQ-015 SHALL have ports oEMPTY and oFULL  output  1 each  fill level ==0 and ==DEPTH.
REQ-016 SHALL have port oOVERRUN  output  1  sticky flag for a dropped byte.
REQ-017 SHALL have port oIRQ  output  1  level interrupt.
REQ-018 SHALL have port oTIMEOUT  output  1  character-timeout flag.

Function
REQ-019 SHALL write iRX_DATA when iRX_DATA_EN=1 and the FIFO is not full, or when it is full and a pop is accepted in the same cycle.
REQ-020 SHALL accept a pop when iRD_REQ=1 and oEMPTY=0; oRD_DATA and oRD_VALID are registered, one cycle after acceptance.
REQ-021 SHALL ignore iRD_REQ when empty: oRD_VALID stays 0 and oRD_DATA holds its last value.
REQ-022 SHALL wrap read and write pointers modulo DEPTH; oCOUNT +1 on write only, -1 on pop only, unchanged on both or neither.
REQ-023 SHALL drop the byte and set oOVERRUN when a write arrives full without a simultaneous pop; contents are unchanged.
REQ-024 SHALL clear oOVERRUN on iCLR_OVR; a simultaneous new overrun wins and the flag stays 1.
REQ-025 SHALL register oIRQ = (iTHRESH!=0 && next oCOUNT>=iTHRESH) || oTIMEOUT, updating one cycle after the count change.
REQ-026 SHALL implement the timeout FSM: IDLE (empty) -> ARMED on write; ARMED counts iRX_TICK while no write and no pop; a write or pop restarts the count at 0.
REQ-027 SHALL move ARMED -> FIRED when the tick count reaches TO_TICKS; oTIMEOUT=1 in FIRED.
REQ-028 SHALL move FIRED -> ARMED on a write or pop leaving the FIFO non-empty, and any state -> IDLE when the FIFO becomes empty.

Reset
REQ-029 SHALL, on iRESET=1 at a clock edge, zero both pointers, oCOUNT, oRD_DATA, oRD_VALID, oOVERRUN, oIRQ, oTIMEOUT and the tick counter, and set the FSM to IDLE.
REQ-030 SHALL give oEMPTY=1 and oFULL=0 after reset; storage contents are not reset.
REQ-031 SHALL, on reset during traffic, discard all stored bytes, with no oRD_VALID in the reset cycle.

Configuration
REQ-032 SHALL compile the timeout FSM and oTIMEOUT only when macro UART_RX_TIMEOUT_EN is defined.
REQ-033 SHALL, without UART_RX_TIMEOUT_EN, tie oTIMEOUT to 0, have no tick counter, and compute oIRQ from the threshold term only.

Verification
REQ-034 SHALL cover: write 0x11,0x22,0x33, then three pops -> oRD_DATA 0x11,0x22,0x33 each one cycle after the pop, with oCOUNT 3->0 and oEMPTY=1.
REQ-035 SHALL cover: DEPTH=8 plus a ninth write 0xAA -> oOVERRUN=1, oCOUNT=8, and the first pop returns the first byte; iCLR_OVR then gives oOVERRUN=0.
REQ-036 SHALL cover: full with write and pop in the same cycle -> oCOUNT stays 8, no overrun, and the new byte is read last.
REQ-037 SHALL cover: iTHRESH=4 with four writes -> oIRQ rises the cycle after the fourth write; one pop -> oIRQ falls.
REQ-038 SHALL cover: with UART_RX_TIMEOUT_EN, one byte then 32 idle ticks -> oTIMEOUT=1 and oIRQ=1; a pop empties the FIFO -> both flags 0.
REQ-039 SHALL cover: iRESET asserted with 5 bytes stored -> oCOUNT=0, oEMPTY=1 and all flags 0 on the next cycle; a pop then gives no oRD_VALID.

Source files
------------

// File: rtl/uart_rx_buf_ctrl.sv
// uart_rx_buf_ctrl: receive-side byte FIFO for a UART. It provides fill level,
// empty/full flags, a sticky overrun flag and a threshold interrupt.
// Optional feature macro: UART_RX_TIMEOUT_EN adds a character-timeout FSM that
// drives oTIMEOUT and feeds it into oIRQ. Without the macro, oTIMEOUT is tied to 0.
module uart_rx_buf_ctrl #(
  parameter int DEPTH    = 8,
  parameter int TO_TICKS = 32,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          iCLK,
  input  logic          iRESET,
  input  logic [7:0]    iRX_DATA,
  input  logic          iRX_DATA_EN,
  input  logic          iRX_TICK,
  input  logic          iRD_REQ,
  input  logic [AW:0]   iTHRESH,
  input  logic          iCLR_OVR,
  output logic [7:0]    oRD_DATA,
  output logic          oRD_VALID,
  output logic [AW:0]   oCOUNT,
  output logic          oEMPTY,
  output logic          oFULL,
  output logic          oOVERRUN,
  output logic          oIRQ,
  output logic          oTIMEOUT
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic [7:0]    rd_data_reg;
  logic          rd_valid_reg;
  logic          ovr_reg;
  logic          irq_reg;
  logic          irq_next;
  logic          thresh_hit;
  logic          pop;
  logic          wr;
  logic          drop;

  assign oEMPTY = (count_reg == '0);
  assign oFULL  = (count_reg == (AW+1)'(DEPTH));

  // A pop frees a slot in the same cycle, so a write to a full FIFO is accepted
  // when it is paired with a pop.
  assign pop  = iRD_REQ && !oEMPTY;
  assign wr   = iRX_DATA_EN && (!oFULL || pop);
  assign drop = iRX_DATA_EN && oFULL && !pop;

  // Next fill level: a simultaneous write and pop leave the count unchanged.
  always_comb begin
    count_next = count_reg;
    case ({wr, pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  assign thresh_hit = (iTHRESH != '0) && (count_next >= iTHRESH);

  // Storage array. The contents are not reset, so this maps onto block RAM.
  always_ff @(posedge iCLK) begin
    if (wr) begin
      mem[wr_ptr_reg] <= iRX_DATA;
    end
  end

  // Pointers, count, registered read port, overrun flag and interrupt.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      ovr_reg      <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      rd_valid_reg <= pop;
      if (pop) begin
        rd_data_reg <= mem[rd_ptr_reg];
        rd_ptr_reg  <= rd_ptr_reg + AW'(1);
      end
      if (wr) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
      // A new drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
        ovr_reg <= 1'b1;
      end else if (iCLR_OVR) begin
        ovr_reg <= 1'b0;
      end
      irq_reg <= irq_next;
    end
  end

  assign oRD_DATA  = rd_data_reg;
  assign oRD_VALID = rd_valid_reg;
  assign oCOUNT    = count_reg;
  assign oOVERRUN  = ovr_reg;
  assign oIRQ      = irq_reg;

`ifdef UART_RX_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, ARMED, FIRED} to_state_t;

  to_state_t state_reg;
  to_state_t state_next;
  logic [7:0] tick_cnt_reg;
  logic [7:0] tick_cnt_next;

  // Timeout state register and idle-tick counter.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
    end
  end

  // Timeout next-state logic. Any write or pop restarts the idle count.
  // An empty FIFO always returns the FSM to IDLE.
  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    if (count_next == '0) begin
      state_next    = IDLE;
      tick_cnt_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next    = ARMED;
          tick_cnt_next = '0;
        end
        ARMED: begin
          if (wr || pop) begin
            tick_cnt_next = '0;
          end else if (iRX_TICK) begin
            if (tick_cnt_reg == 8'(TO_TICKS - 1)) begin
              state_next    = FIRED;
              tick_cnt_next = '0;
            end else begin
              tick_cnt_next = tick_cnt_reg + 8'd1;
            end
          end
        end
        FIRED: begin
          if (wr || pop) begin
            state_next    = ARMED;
            tick_cnt_next = '0;
          end
        end
        default: begin
          state_next    = IDLE;
          tick_cnt_next = '0;
        end
      endcase
    end
  end

  assign oTIMEOUT = (state_reg == FIRED);
  // Use the next timeout state so oIRQ and oTIMEOUT change in the same cycle.
  assign irq_next = thresh_hit || (state_next == FIRED);
`else
  logic tick_unused;
  assign tick_unused = iRX_TICK;
  assign oTIMEOUT    = 1'b0;
  assign irq_next    = thresh_hit;
`endif

endmodule

// File: tb/tb_uart_rx_buf_ctrl.sv
// Scoreboard testbench for uart_rx_buf_ctrl (DEPTH=8, TO_TICKS=32).
// Each pop pushes the expected byte into a queue. A negedge monitor compares
// every oRD_VALID pulse against the head of that queue.
module tb_uart_rx_buf_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_en;
  logic       rx_tick;
  logic       rd_req;
  logic [3:0] thresh;
  logic       clr_ovr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic       overrun;
  logic       irq;
  logic       timeout;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  uart_rx_buf_ctrl #(.DEPTH(8), .TO_TICKS(32)) dut (
    .iCLK(clk), .iRESET(rst), .iRX_DATA(rx_data), .iRX_DATA_EN(rx_en),
    .iRX_TICK(rx_tick), .iRD_REQ(rd_req), .iTHRESH(thresh), .iCLR_OVR(clr_ovr),
    .oRD_DATA(rd_data), .oRD_VALID(rd_valid), .oCOUNT(count), .oEMPTY(empty),
    .oFULL(full), .oOVERRUN(overrun), .oIRQ(irq), .oTIMEOUT(timeout)
  );

  // Monitor: every read pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got oRD_DATA=%02h, no read pending", rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %02h, expected %02h", rd_data, e);
        end else begin
          $display("read   %02h ok", rd_data);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("check  %s = %0d ok", name, act);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    rx_data = b; rx_en = 1'b1;
    cyc();
    rx_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] e);
    exp_q.push_back(e);
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      rx_tick = 1'b1; cyc();
      rx_tick = 1'b0; cyc();
    end
  endtask

  initial begin
    rst = 1'b1; rx_data = '0; rx_en = 1'b0; rx_tick = 1'b0;
    rd_req = 1'b0; thresh = '0; clr_ovr = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("reset_count", count, 0);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_ovr", overrun, 0);
    chk("reset_irq", irq, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_rdvalid", rd_valid, 0);

    // Three writes, then three pops in order.
    wr(8'h11); wr(8'h22); wr(8'h33);
    chk("basic_count3", count, 3);
    rd(8'h11); chk("basic_valid_lat", rd_valid, 1); chk("basic_count2", count, 2);
    rd(8'h22); chk("basic_count1", count, 1);
    rd(8'h33); chk("basic_count0", count, 0);
    chk("basic_empty", empty, 1);
    // A pop on an empty FIFO is ignored and the output data is held.
    rd_req = 1'b1; cyc(); rd_req = 1'b0;
    chk("empty_pop_valid", rd_valid, 0);
    chk("empty_pop_hold", rd_data, 8'h33);

    // Fill, then overrun.
    for (int i = 1; i <= 8; i++) wr(8'(i));
    chk("fill_count8", count, 8);
    chk("fill_full", full, 1);
    wr(8'hAA);
    chk("ovr_set", overrun, 1);
    chk("ovr_count8", count, 8);
    rx_data = 8'hBB; rx_en = 1'b1; clr_ovr = 1'b1; cyc();
    rx_en = 1'b0; clr_ovr = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    rd(8'h01);
    clr_ovr = 1'b1; cyc(); clr_ovr = 1'b0;
    chk("ovr_clear", overrun, 0);
    for (int i = 2; i <= 8; i++) rd(8'(i));
    chk("ovr_drain_empty", empty, 1);

    // When full, a write and a pop in the same cycle both take effect.
    for (int i = 0; i < 8; i++) wr(8'h10 + 8'(i));
    exp_q.push_back(8'h10);
    rx_data = 8'h5A; rx_en = 1'b1; rd_req = 1'b1; cyc();
    rx_en = 1'b0; rd_req = 1'b0;
    chk("wp_count8", count, 8);
    chk("wp_no_ovr", overrun, 0);
    for (int i = 1; i < 8; i++) rd(8'h10 + 8'(i));
    rd(8'h5A);
    chk("wp_empty", empty, 1);

    // Threshold interrupt.
    thresh = 4'd4;
    wr(8'h41); wr(8'h42); wr(8'h43);
    chk("irq_below", irq, 0);
    wr(8'h44);
    chk("irq_rise", irq, 1);
    rd(8'h41);
    chk("irq_fall", irq, 0);
    wr(8'h45);
    chk("irq_rise2", irq, 1);
    thresh = 4'd0; cyc();
    chk("irq_disabled", irq, 0);
    rd(8'h42); rd(8'h43); rd(8'h44); rd(8'h45);

`ifdef UART_RX_TIMEOUT_EN
    // Character timeout.
    wr(8'h77);
    ticks(31);
    chk("to_not_yet", timeout, 0);
    ticks(1);
    chk("to_fired", timeout, 1);
    chk("to_irq", irq, 1);
    rd(8'h77);
    chk("to_pop_clear", timeout, 0);
    chk("to_pop_irq", irq, 0);
    wr(8'h61); ticks(20);
    wr(8'h62); ticks(20);
    chk("to_restart", timeout, 0);
    ticks(12);
    chk("to_fired2", timeout, 1);
    wr(8'h63);
    chk("to_rearm", timeout, 0);
    rd(8'h61); rd(8'h62); rd(8'h63);
`else
    wr(8'h77);
    ticks(40);
    chk("to_disabled", timeout, 0);
    chk("to_disabled_irq", irq, 0);
    rd(8'h77);
`endif

    // Reset during traffic.
    thresh = 4'd4;
    for (int i = 0; i < 5; i++) wr(8'hB1 + 8'(i));
    chk("pre_rst_count", count, 5);
    chk("pre_rst_irq", irq, 1);
    rst = 1'b1; rd_req = 1'b1; cyc();
    rst = 1'b0; rd_req = 1'b0;
    chk("rst_rdvalid", rd_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ovr", overrun, 0);
    chk("rst_irq", irq, 0);
    chk("rst_timeout", timeout, 0);
    rd_req = 1'b1; cyc(); rd_req = 1'b0;
    chk("rst_pop_valid", rd_valid, 0);
    thresh = 4'd0;

    cyc(); cyc();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
